// File: rtl/tx_serializer.sv
// tx_serializer: FIFO-fed serial transmitter (start, LSB-first data, optional even parity, stop).
// Optional feature macro: TX_SERIALIZER_PARITY_EN adds the PARITY state and parity bit.
module tx_serializer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef TX_SERIALIZER_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  baud_last_s;

`ifdef TX_SERIALIZER_PARITY_EN
  logic parity_q, parity_d;

  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    state_d     = state_q;
    baud_d      = '0;
    bit_d       = bit_q;
    shift_d     = shift_q;
    baud_last_s = (baud_q == BAUD_LAST);
`ifdef TX_SERIALIZER_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = READ;
        else             state_d = IDLE;
      end
      READ: state_d = LOAD;
      LOAD: begin
        shift_d = fifo_data;
        bit_d   = '0;
`ifdef TX_SERIALIZER_PARITY_EN
        parity_d = even_parity(fifo_data);
`endif
        state_d = START;
      end
      START: begin
        if (baud_last_s) state_d = DATA;
        else             baud_d  = baud_q + BAUD_W'(1);
      end
      DATA: begin
        if (!baud_last_s) begin
          baud_d = baud_q + BAUD_W'(1);
        end else if (bit_q == BIT_LAST) begin
`ifdef TX_SERIALIZER_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          bit_d   = bit_q + BIT_W'(1);
          shift_d = shift_q >> 1;
        end
      end
`ifdef TX_SERIALIZER_PARITY_EN
      PARITY: begin
        if (baud_last_s) state_d = STOP;
        else             baud_d  = baud_q + BAUD_W'(1);
      end
`endif
      STOP: begin
        if (baud_last_s) state_d = IDLE;
        else             baud_d  = baud_q + BAUD_W'(1);
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef TX_SERIALIZER_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
    rd_en_d = (state_d == READ);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == STOP) && (baud_d == BAUD_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef TX_SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      rd_en_q  <= rd_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef TX_SERIALIZER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
